dg_nibble_ram: RTL and testbench

Parametrised scratch RAM for the DG-series puzzle cores. It replaces the fixed 64×4 OR-merge store with a configurable-width/depth array. The array has independent write and read ports, four write-merge modes, a registered read port with a valid flag and a complement output, and a hardware clear sweep. The clear sweep runs after reset and on request. The block sits between the pad-mapped input bus and the output mux of the top-level tile.

---
 rtl/dg_nibble_ram.sv | 124 ++++++++++++
 tb/tb_dg_nibble_ram.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dg_nibble_ram.sv
// dg_nibble_ram: parametrised scratch RAM for the DG-series puzzle cores.
// It has independent write and read ports, four write-merge modes and a
// registered read port with valid flag and complement output. A hardware
// clear sweep runs after reset and whenever a clear is requested.
module dg_nibble_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic              clr_req_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_mode_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] rd_data_n_o,
  output logic              rd_valid_o,
  output logic              busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_data_n_q, rd_data_n_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] merged;

  // Merge the incoming word with the stored word for read-modify-write.
  always_comb begin
    merged = wr_data_i;
    case (wr_mode_i)
      2'b00:   merged = wr_data_i;
      2'b01:   merged = mem_q[wr_addr_i] | wr_data_i;
      2'b10:   merged = mem_q[wr_addr_i] ^ wr_data_i;
      default: merged = mem_q[wr_addr_i] & wr_data_i;
    endcase
  end

  // Next-state logic: clear sweep, read port, write port and clear requests.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    if (ena_i) begin
      rd_valid_d = 1'b0;
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end else begin
        if (rd_en_i) begin
          rd_data_d  = mem_q[rd_addr_i];
          rd_valid_d = 1'b1;
        end
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (wr_en_i) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr_i;
          mem_wdata = merged;
        end
      end
    end
    rd_data_n_d = ~rd_data_d;
    busy_d      = (state_d == ST_CLEAR);
  end

  // Array storage; contents are only meaningful once a sweep has completed.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      rd_data_q   <= '0;
      rd_data_n_q <= '1;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_data_q   <= rd_data_d;
      rd_data_n_q <= rd_data_n_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_data_n_o = rd_data_n_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dg_nibble_ram.sv
// Testbench for dg_nibble_ram: a default 4x64 instance checked against a
// behavioural model under directed and random traffic, and an 8x4 instance
// for the parameter corner.
module tb_dg_nibble_ram;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=4, ADDR_W=6
  logic       rstN, ena, clrReq, wrEn, rdEn;
  logic [1:0] wrMode;
  logic [5:0] wrAddr, rdAddr;
  logic [3:0] wrData, rdData, rdDataN;
  logic       rdValid, busy;

  // Instance B: DATA_W=8, ADDR_W=2
  logic       rstNB, enaB, clrReqB, wrEnB, rdEnB;
  logic [1:0] wrModeB;
  logic [1:0] wrAddrB, rdAddrB;
  logic [7:0] wrDataB, rdDataB, rdDataNB;
  logic       rdValidB, busyB;

  dg_nibble_ram #(.DATA_W(4), .ADDR_W(6)) dutA (
    .clk_i(clk), .rst_ni(rstN), .ena_i(ena), .clr_req_i(clrReq),
    .wr_en_i(wrEn), .wr_mode_i(wrMode), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .rd_data_o(rdData),
    .rd_data_n_o(rdDataN), .rd_valid_o(rdValid), .busy_o(busy)
  );

  dg_nibble_ram #(.DATA_W(8), .ADDR_W(2)) dutB (
    .clk_i(clk), .rst_ni(rstNB), .ena_i(enaB), .clr_req_i(clrReqB),
    .wr_en_i(wrEnB), .wr_mode_i(wrModeB), .wr_addr_i(wrAddrB), .wr_data_i(wrDataB),
    .rd_en_i(rdEnB), .rd_addr_i(rdAddrB), .rd_data_o(rdDataB),
    .rd_data_n_o(rdDataNB), .rd_valid_o(rdValidB), .busy_o(busyB)
  );

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model for instance A
  logic [3:0] refMem [DEPTH];
  logic [3:0] refRd;
  logic       refValid;
  int         clearLeft;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] mergeWord(input logic [3:0] old, input logic [3:0] d,
                                           input logic [1:0] mode);
    case (mode)
      2'd0:    return d;
      2'd1:    return old | d;
      2'd2:    return old ^ d;
      default: return old & d;
    endcase
  endfunction

  // A completed sweep leaves every word zero and nothing readable meanwhile,
  // so the model zeroes its array up front and just counts the sweep down.
  task automatic modelStartClear();
    for (int i = 0; i < DEPTH; i++) refMem[i] = 4'h0;
    clearLeft = DEPTH;
  endtask

  task automatic modelReset();
    refRd    = 4'h0;
    refValid = 1'b0;
    modelStartClear();
  endtask

  task automatic modelEdge();
    if (!rstN || !ena) return;
    if (clearLeft > 0) begin
      refValid = 1'b0;
      clearLeft--;
    end else begin
      if (rdEn) begin
        refRd    = refMem[rdAddr];
        refValid = 1'b1;
      end else begin
        refValid = 1'b0;
      end
      if (clrReq) modelStartClear();
      else if (wrEn) refMem[wrAddr] = mergeWord(refMem[wrAddr], wrData, wrMode);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [3:0] nExp;
    nExp = ~refRd;
    checkOutput({tag, "_rd_data"}, 32'(rdData), 32'(refRd));
    checkOutput({tag, "_rd_data_n"}, 32'(rdDataN), 32'(nExp));
    checkOutput({tag, "_rd_valid"}, 32'(rdValid), 32'(refValid));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(clearLeft > 0));
  endtask

  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  task automatic randomInputs(input int clrPercent, input int addrMax);
    clrReq = ($urandom_range(0, 99) < clrPercent);
    wrEn   = 1'($urandom_range(0, 1));
    rdEn   = 1'($urandom_range(0, 1));
    wrMode = 2'($urandom_range(0, 3));
    wrAddr = 6'($urandom_range(0, addrMax));
    rdAddr = 6'($urandom_range(0, addrMax));
    wrData = 4'($urandom_range(0, 15));
  endtask

  task automatic idleInputs();
    clrReq = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
    wrMode = 2'd0; wrAddr = 6'd0; rdAddr = 6'd0; wrData = 4'h0;
  endtask

  task automatic doWrite(input logic [5:0] a, input logic [3:0] d, input logic [1:0] m);
    idleInputs();
    wrEn = 1'b1; wrAddr = a; wrData = d; wrMode = m;
    applyStimulus("write");
  endtask

  task automatic doRead(input logic [5:0] a);
    idleInputs();
    rdEn = 1'b1; rdAddr = a;
    applyStimulus("read");
  endtask

  // Runs random ignored traffic until busy drops; returns the edge count.
  task automatic runSweep(output int n);
    n = 0;
    do begin
      randomInputs(30, 63);
      rdEn = 1'b1;
      applyStimulus("sweep");
      n++;
    end while (busy === 1'b1 && n < 200);
  endtask

  initial begin
    int n;
    rstN = 1'b0; ena = 1'b1; idleInputs();
    rstNB = 1'b0; enaB = 1'b1; clrReqB = 1'b0; wrEnB = 1'b0; rdEnB = 1'b0;
    wrModeB = 2'd0; wrAddrB = 2'd0; rdAddrB = 2'd0; wrDataB = 8'h00;
    modelReset();

    #12;
    checkOutput("reset_rd_data", 32'(rdData), 32'h0);
    checkOutput("reset_rd_data_n", 32'(rdDataN), 32'hF);
    checkOutput("reset_rd_valid", 32'(rdValid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h1);
    rstN = 1'b1;

    runSweep(n);
    checkOutput("sweep_len_after_reset", 32'(n), 32'd64);

    for (int i = 0; i < DEPTH; i++) begin
      doRead(6'(i));
      checkOutput("read_zero", 32'(rdData), 32'h0);
      checkOutput("read_zero_n", 32'(rdDataN), 32'hF);
      checkOutput("read_zero_valid", 32'(rdValid), 32'h1);
    end

    doWrite(6'd5, 4'hA, 2'd0);
    doWrite(6'd5, 4'h5, 2'd1);
    doRead(6'd5);
    checkOutput("mode_or", 32'(rdData), 32'hF);
    doWrite(6'd5, 4'h3, 2'd2);
    doRead(6'd5);
    checkOutput("mode_xor", 32'(rdData), 32'hC);
    doWrite(6'd5, 4'h6, 2'd3);
    doRead(6'd5);
    checkOutput("mode_and", 32'(rdData), 32'h4);

    doWrite(6'd12, 4'hA, 2'd0);
    doWrite(6'd12, 4'h5, 2'd1);
    doWrite(6'd12, 4'h3, 2'd2);
    doWrite(6'd12, 4'h6, 2'd3);
    doRead(6'd12);
    checkOutput("back_to_back_merge", 32'(rdData), 32'h4);

    doWrite(6'd9, 4'h2, 2'd0);
    idleInputs();
    rdEn = 1'b1; rdAddr = 6'd9; wrEn = 1'b1; wrAddr = 6'd9; wrData = 4'h7;
    applyStimulus("same_edge");
    checkOutput("read_first", 32'(rdData), 32'h2);
    doRead(6'd9);
    checkOutput("read_after_same_edge", 32'(rdData), 32'h7);

    doWrite(6'd3, 4'h1, 2'd0);
    idleInputs();
    clrReq = 1'b1; wrEn = 1'b1; wrAddr = 6'd3; wrData = 4'hF; rdEn = 1'b1; rdAddr = 6'd3;
    applyStimulus("clr_accept");
    checkOutput("clr_read_served", 32'(rdData), 32'h1);
    checkOutput("clr_busy", 32'(busy), 32'h1);
    runSweep(n);
    checkOutput("sweep_len_after_clr", 32'(n), 32'd64);
    doRead(6'd3);
    checkOutput("clr_wins_over_write", 32'(rdData), 32'h0);

    idleInputs();
    clrReq = 1'b1;
    applyStimulus("clr_pause");
    for (int i = 0; i < 20; i++) begin
      randomInputs(30, 63);
      applyStimulus("pre_pause");
    end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      randomInputs(50, 63);
      applyStimulus("ena_low_sweep");
    end
    ena = 1'b1;
    runSweep(n);
    checkOutput("sweep_resume_len", 32'(n), 32'd44);

    doWrite(6'd10, 4'h6, 2'd0);
    ena = 1'b0;
    idleInputs();
    wrEn = 1'b1; wrAddr = 6'd10; wrData = 4'h9;
    applyStimulus("ena_low_write");
    ena = 1'b1;
    doRead(6'd10);
    checkOutput("ena_low_no_write", 32'(rdData), 32'h6);

    for (int i = 0; i < 400; i++) begin
      randomInputs(1, 15);
      ena = ($urandom_range(0, 9) != 0);
      applyStimulus("random");
    end
    ena = 1'b1;
    for (int i = 0; i < 70; i++) begin
      idleInputs();
      applyStimulus("drain");
    end

    doWrite(6'd20, 4'h8, 2'd0);
    doRead(6'd20);
    #3;
    rstN = 1'b0;
    modelReset();
    #1;
    checkModel("async_reset_a");
    #2;
    rstN = 1'b1;
    runSweep(n);
    checkOutput("sweep_len_after_mid_reset", 32'(n), 32'd64);

    @(posedge clk); #3;
    rstNB = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busyB === 1'b1 && n < 50);
    checkOutput("b_sweep_len", 32'(n), 32'd4);
    wrEnB = 1'b1; wrModeB = 2'd2; wrAddrB = 2'd3; wrDataB = 8'hFF;
    @(posedge clk); #1;
    wrEnB = 1'b0; rdEnB = 1'b1; rdAddrB = 2'd3;
    @(posedge clk); #1;
    rdEnB = 1'b0;
    checkOutput("b_xor_data", 32'(rdDataB), 32'hFF);
    checkOutput("b_xor_data_n", 32'(rdDataNB), 32'h00);
    checkOutput("b_xor_valid", 32'(rdValidB), 32'h1);
    #3;
    rstNB = 1'b0;
    #1;
    checkOutput("b_async_valid", 32'(rdValidB), 32'h0);
    checkOutput("b_async_data", 32'(rdDataB), 32'h00);
    checkOutput("b_async_data_n", 32'(rdDataNB), 32'hFF);
    checkOutput("b_async_busy", 32'(busyB), 32'h1);
    #2;
    rstNB = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
